// File: rtl/regfile_wb_scoreboard.sv
// Writeback controller for the 31-entry register file: busy-bit scoreboard with
// RAW/WAW issue stalls and ALU/LSU arbitration onto the single write port.
module regfile_wb_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rs1_i,
  input  logic              issue_rs1_used_i,
  input  logic [4:0]        issue_rs2_i,
  input  logic              issue_rs2_used_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              issue_rd_wr_i,
  output logic              issue_ready_o,
  input  logic              alu_wb_valid_i,
  input  logic [4:0]        alu_wb_rd_i,
  input  logic [DATA_W-1:0] alu_wb_data_i,
  input  logic              lsu_wb_valid_i,
  input  logic [4:0]        lsu_wb_rd_i,
  input  logic [DATA_W-1:0] lsu_wb_data_i,
  output logic              lsu_wb_ready_o,
  output logic              reg_wr_en_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [31:0]       busy_o,
  output logic              wb_err_o
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned NUM_RF = 32;
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  typedef struct packed {
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic [NUM_RF-1:0] busy_q;
  logic [NUM_RF-1:0] busy_d;
  logic [WAIT_W-1:0] wait_q;
  logic              throttle;
  logic              raw_hazard;
  logic              waw_hazard;
  logic              issue_fire;
  logic              gnt_valid;
  wb_req_t           gnt;

  // Hazards look only at registered busy bits; a cleared entry is usable the cycle after commit.
  assign raw_hazard = (issue_rs1_used_i & busy_q[issue_rs1_i]) |
                      (issue_rs2_used_i & busy_q[issue_rs2_i]);
  assign waw_hazard = issue_rd_wr_i & busy_q[issue_rd_i];
  assign throttle   = (wait_q == MAX_CNT);

  assign issue_ready_o  = rst_ni & ~raw_hazard & ~waw_hazard & ~throttle;
  assign issue_fire     = issue_valid_i & issue_ready_o;
  assign lsu_wb_ready_o = rst_ni & lsu_wb_valid_i & ~alu_wb_valid_i;

  // ALU cannot be back-pressured, so it always wins the write port.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (alu_wb_valid_i) begin
      gnt_valid = 1'b1;
      gnt.rd    = alu_wb_rd_i;
      gnt.data  = alu_wb_data_i;
    end else if (lsu_wb_ready_o) begin
      gnt_valid = 1'b1;
      gnt.rd    = lsu_wb_rd_i;
      gnt.data  = lsu_wb_data_i;
    end
  end

  // Clear on commit, then set on issue so a same-index collision resolves to busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_wr_en_o) begin
      busy_d[rd_addr_o] = 1'b0;
    end
    if (issue_fire && issue_rd_wr_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  // Write port: registered one cycle after the grant; address/data hold when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_wr_en_o <= 1'b0;
      rd_addr_o   <= '0;
      wr_data_o   <= '0;
    end else if (gnt_valid) begin
      reg_wr_en_o <= (gnt.rd != '0);
      rd_addr_o   <= gnt.rd;
      wr_data_o   <= gnt.data;
    end else begin
      reg_wr_en_o <= 1'b0;
    end
  end

  // Sticky flag for a writeback that targets a register nothing is waiting on.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_err_o <= 1'b0;
    end else if (gnt_valid && (gnt.rd != '0) && !busy_q[gnt.rd]) begin
      wb_err_o <= 1'b1;
    end
  end

  // Counts consecutive LSU-blocked cycles; saturating value throttles issue to drain the ALU.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (!lsu_wb_valid_i || lsu_wb_ready_o) begin
      wait_q <= '0;
    end else if (wait_q != MAX_CNT) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Controller in front of the 31-entry register file. It owns the file's single write port and its write-enable.
- Tracks in-flight destination registers with a busy-bit scoreboard and stalls issue on RAW/WAW hazards.
- Arbitrates two writeback sources onto the one write port: the fixed-latency ALU pipe and the variable-latency LSU.
- Sits between decode/issue and the register file. Its registered write outputs drive the file's write port directly.

Parameters:
- DATA_W, 32, writeback data width.
- MAX_WAIT, 4, consecutive LSU-blocked cycles before issue is throttled to drain the ALU pipe.
- WAIT_W, 3, width of the LSU wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- issue_valid_i  in  1  instruction presented for issue
- issue_rs1_i  in  5  source 1 register index
- issue_rs1_used_i  in  1  rs1 is read
- issue_rs2_i  in  5  source 2 register index
- issue_rs2_used_i  in  1  rs2 is read
- issue_rd_i  in  5  destination register index
- issue_rd_wr_i  in  1  instruction writes rd
- issue_ready_o  out  1  issue accepted this cycle when valid and ready
- alu_wb_valid_i  in  1  ALU writeback (cannot be stalled)
- alu_wb_rd_i  in  5  ALU destination index
- alu_wb_data_i  in  DATA_W  ALU result
- lsu_wb_valid_i  in  1  LSU writeback request
- lsu_wb_rd_i  in  5  LSU destination index
- lsu_wb_data_i  in  DATA_W  load data
- lsu_wb_ready_o  out  1  LSU writeback granted this cycle
- reg_wr_en_o  out  1  register file write enable
- rd_addr_o  out  5  register file write index
- wr_data_o  out  DATA_W  register file write data
- busy_o  out  32  scoreboard busy bits; bit 0 is always 0
- wb_err_o  out  1  sticky flag: writeback to a non-busy register

Behaviour:
- Reset, while rst_ni=0 at posedge:
  - busy, reg_wr_en_o, rd_addr_o, wr_data_o, wb_err_o and the wait counter are all 0.
  - issue_ready_o=0 and lsu_wb_ready_o=0 combinationally while rst_ni=0.
  - Reset mid-operation drops all pending state; no write is issued afterwards for pre-reset grants.
- Hazard, combinational on the registered busy bits only (no bypass):
  - RAW = (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]).
  - WAW = rd_wr & busy[rd].
  - issue_ready_o = ~RAW & ~WAW & ~throttle.
- Set: on issue accept with rd_wr=1 and rd≠0, busy[rd] is set at that edge. rd=0 never sets busy.
- Arbitration, combinational:
  - ALU has absolute priority.
  - lsu_wb_ready_o = lsu_wb_valid_i & ~alu_wb_valid_i.
  - The LSU must hold rd and data stable while valid and not ready.
- Write port, registered with 1-cycle latency:
  - At the posedge after a grant, reg_wr_en_o=1, rd_addr_o=granted rd, wr_data_o=granted data.
  - A grant with rd=0 gives reg_wr_en_o=0 and no busy change.
  - No grant gives reg_wr_en_o=0; rd_addr_o and wr_data_o hold their previous values.
- Clear:
  - busy[rd_addr_o] clears at the posedge where reg_wr_en_o=1, i.e. the same edge the file commits the write.
  - A dependent instruction can therefore issue in the following cycle, and its registered read sees the new value.
  - Minimum RAW distance from grant to dependent issue: 2 cycles.
- Set and clear of the same index in the same cycle: set wins. This is unreachable legally, because the WAW stall blocks it.
- Error: if a grant targets rd≠0 with busy[rd]=0, the write still proceeds and wb_err_o sets (sticky until reset).
- Throttle and wait counter:
  - The counter increments each cycle lsu_wb_valid_i=1 and lsu_wb_ready_o=0.
  - It saturates at MAX_WAIT and clears on LSU grant or when lsu_wb_valid_i=0.
  - throttle = (counter==MAX_WAIT). While throttled, issue_ready_o=0 so no new ALU ops enter and the ALU pipe drains, guaranteeing the LSU grant.

Test Plan:
- Reset → all outputs 0; release reset, issue rd=5, rs1=rs2 unused → ready=1, busy_o=0x0000_0020 next cycle.
- RAW: issue rd=5; next cycle issue rs1=5 → ready=0. ALU wb rd=5, data=0xDEADBEEF → next cycle reg_wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF. Following cycle busy_o[5]=0 and ready=1.
- Conflict: ALU wb rd=3 and LSU wb rd=4 same cycle → lsu_wb_ready_o=0, ALU written first. Next cycle LSU granted, wr_data_o = LSU data one cycle later. Both busy bits cleared.
- Starvation: hold alu_wb_valid_i=1 and LSU valid for 4 cycles → issue_ready_o=0 from cycle 5. Drop ALU valid → LSU granted, counter clears, issue_ready_o returns to 1.
- x0: issue rd=0 → busy_o unchanged. ALU wb rd=0 → reg_wr_en_o stays 0 and wb_err_o stays 0.
- Error and mid-reset: ALU wb rd=7 with busy[7]=0 → write occurs, wb_err_o=1. Assert rst_ni=0 one cycle → wb_err_o=0, busy_o=0, reg_wr_en_o=0.
